// File: rtl/galetron_pkg.sv
// galetron_pkg: shared widths, RAM depth and copy FSM state encoding
package galetron_pkg;
    localparam int ADDR_WIDTH = 10;
    localparam int DATA_WIDTH = 32;
    localparam int RAM_DEPTH  = 271;
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} copy_state_e;
endpackage

// File: rtl/ram_copy_engine_if.sv
// ram_copy_engine_if: request, status and data-RAM signals of the copy engine
interface ram_copy_engine_if #(
    parameter int ADDR_WIDTH = galetron_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = galetron_pkg::DATA_WIDTH
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] sourceAddress;
    logic [ADDR_WIDTH-1:0] destinationAddress;
    logic [ADDR_WIDTH-1:0] wordCount;
    logic [DATA_WIDTH-1:0] ramDataIn;
    logic [ADDR_WIDTH-1:0] ramAddress;
    logic [DATA_WIDTH-1:0] ramDataOut;
    logic                  ramWriteEnable;
    logic                  busy;
    logic                  done;
    logic                  error;
    modport master (
        output start, sourceAddress, destinationAddress, wordCount, ramDataIn,
        input  ramAddress, ramDataOut, ramWriteEnable, busy, done, error
    );
    modport slave (
        input  start, sourceAddress, destinationAddress, wordCount, ramDataIn,
        output ramAddress, ramDataOut, ramWriteEnable, busy, done, error
    );
endinterface

// File: rtl/copy_address_generator.sv
// copy_address_generator: source/destination pointers and remaining-word count
module copy_address_generator #(
    parameter int ADDR_WIDTH = galetron_pkg::ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  step,
    input  logic                  descending,
    input  logic [ADDR_WIDTH-1:0] source,
    input  logic [ADDR_WIDTH-1:0] destination,
    input  logic [ADDR_WIDTH-1:0] count,
    output logic [ADDR_WIDTH-1:0] source_pointer,
    output logic [ADDR_WIDTH-1:0] destination_pointer,
    output logic                  zero
);
    localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);
    logic                  dir_down;
    logic [ADDR_WIDTH-1:0] remaining;
    always_ff @(posedge clock) begin
        if (reset) begin
            dir_down            <= 1'b0;
            remaining           <= '0;
            source_pointer      <= '0;
            destination_pointer <= '0;
        end else if (load) begin
            dir_down            <= descending;
            remaining           <= count;
            source_pointer      <= descending ? source + count - ONE : source;
            destination_pointer <= descending ? destination + count - ONE : destination;
        end else if (step) begin
            remaining           <= remaining - ONE;
            source_pointer      <= dir_down ? source_pointer - ONE : source_pointer + ONE;
            destination_pointer <= dir_down ? destination_pointer - ONE : destination_pointer + ONE;
        end
    end
    // flags the count that results once the current step lands
    assign zero = (step ? remaining - ONE : remaining) == '0;
endmodule

// File: rtl/ram_copy_engine.sv
// ram_copy_engine: overlap-safe word copy within a single-port data RAM
module ram_copy_engine #(
    parameter int RAM_DEPTH  = galetron_pkg::RAM_DEPTH,
    parameter int ADDR_WIDTH = galetron_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = galetron_pkg::DATA_WIDTH
) (
    input logic             clock,
    input logic             reset,
    ram_copy_engine_if.slave bus
);
    import galetron_pkg::*;
    localparam logic [ADDR_WIDTH:0] DEPTH = (ADDR_WIDTH+1)'(RAM_DEPTH);
    copy_state_e           state, next_state;
    logic                  error_q, load, step, zero, zero_len, range_error;
    logic [ADDR_WIDTH-1:0] source_pointer, destination_pointer;
    assign zero_len    = bus.wordCount == '0;
    assign range_error = ({1'b0, bus.sourceAddress} + {1'b0, bus.wordCount} > DEPTH) ||
                         ({1'b0, bus.destinationAddress} + {1'b0, bus.wordCount} > DEPTH);
    assign load = state == IDLE && bus.start;
    assign step = state == WRITE;
    // descending order keeps overlapping ranges intact when moving upwards
    copy_address_generator #(.ADDR_WIDTH(ADDR_WIDTH)) address_generator (
        .clock               (clock),
        .reset               (reset),
        .load                (load),
        .step                (step),
        .descending          (bus.destinationAddress > bus.sourceAddress),
        .source              (bus.sourceAddress),
        .destination         (bus.destinationAddress),
        .count               (bus.wordCount),
        .source_pointer      (source_pointer),
        .destination_pointer (destination_pointer),
        .zero                (zero)
    );
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            error_q <= 1'b0;
        end else begin
            state <= next_state;
            if (load) error_q <= range_error && !zero_len;
        end
    end
    always_comb begin
        next_state = state;
        next_state = state == IDLE  ? (bus.start ? ((zero_len || range_error) ? DONE : READ) : IDLE) :
                     state == READ  ? WRITE :
                     state == WRITE ? (zero ? DONE : READ) : IDLE;
        bus.busy           = state == READ || state == WRITE;
        bus.done           = state == DONE;
        bus.error          = error_q;
        bus.ramWriteEnable = state == WRITE;
        bus.ramAddress     = state == READ ? source_pointer : state == WRITE ? destination_pointer : '0;
        bus.ramDataOut     = state == WRITE ? bus.ramDataIn : '0;
    end
endmodule

// File: doc/ram_copy_engine.md
RAM_COPY_ENGINE -- requirements
Module: ram_copy_engine

Interface
REQ-001 The block SHALL have parameter RAM_DEPTH, default 271, giving the number of addressable data RAM words.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 10, giving the address bus width.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 32, giving the data word width.
REQ-004 The block SHALL have port clock, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: copy request, sampled only in IDLE.
REQ-007 The block SHALL have port sourceAddress, input, ADDR_WIDTH bits: first source word.
REQ-008 The block SHALL have port destinationAddress, input, ADDR_WIDTH bits: first destination word.
REQ-009 The block SHALL have port wordCount, input, ADDR_WIDTH bits: number of words to copy.
REQ-010 The block SHALL have port ramDataIn, input, DATA_WIDTH bits, driven by the data RAM read output.
REQ-011 The block SHALL have port ramAddress, output, ADDR_WIDTH bits, driving the data RAM address.
REQ-012 The block SHALL have port ramDataOut, output, DATA_WIDTH bits, driving the data RAM write data.
REQ-013 The block SHALL have port ramWriteEnable, output, 1 bit, driving the data RAM write enable.
REQ-014 The block SHALL have port busy, output, 1 bit: high in READ and WRITE.
REQ-015 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-016 The block SHALL have port error, output, 1 bit: range error flag, held until the next accepted start.

Function
REQ-017 RAM timing SHALL be treated as: read data valid on ramDataIn one cycle after ramAddress is presented; a write completes within the cycle in which ramWriteEnable is high.
REQ-018 The FSM SHALL have four states: IDLE, READ, WRITE, DONE.
REQ-019 In IDLE, start=1 SHALL latch all three request inputs, clear error, and select the next state as follows:
- wordCount=0 -> DONE;
- range error (REQ-020) -> DONE with error=1;
- otherwise -> READ.
REQ-020 A range error SHALL be flagged when sourceAddress+wordCount > RAM_DEPTH or destinationAddress+wordCount > RAM_DEPTH, computed at ADDR_WIDTH+1 bits with no wrap.
REQ-021 The copy direction SHALL be descending (last word first) when destination > source, and ascending otherwise, so that overlapping ranges copy correctly.
REQ-022 READ SHALL drive ramAddress to the current source word with ramWriteEnable=0, then go to WRITE.
REQ-023 WRITE SHALL drive ramAddress to the current destination word, ramDataOut=ramDataIn, and ramWriteEnable=1; it SHALL then decrement the remaining count and step both pointers.
REQ-024 From WRITE, the FSM SHALL go to DONE when the remaining count reaches 0, otherwise back to READ.
REQ-025 DONE SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-026 Latency from the start edge to the done pulse SHALL be 2*wordCount+1 cycles; wordCount=0 or a range error gives 1 cycle.
REQ-027 start asserted outside IDLE SHALL be ignored, with no queuing.
REQ-028 ramWriteEnable SHALL be high only in WRITE, never on an error or zero-length request.
REQ-029 sourceAddress equal to destinationAddress SHALL still perform all reads and writes.

Reset
REQ-030 On reset, the FSM SHALL go to IDLE and drive busy=0, done=0, error=0, ramWriteEnable=0, ramAddress=0, ramDataOut=0.
REQ-031 Reset asserted mid-copy SHALL abort the copy at that edge, with no further writes; words already written remain in RAM.

Structure
REQ-032 A shared package galetron_pkg SHALL hold ADDR_WIDTH, DATA_WIDTH, RAM_DEPTH, and the copy FSM state enum.
REQ-033 Pointer and count stepping SHALL be a sub-module copy_address_generator (load, step, direction, zero flag); the FSM and bounds check stay in ram_copy_engine.

Verification
REQ-034 Preload RAM[10..13]=A,B,C,D; start src=10, dst=100, count=4 -> RAM[100..103]=A,B,C,D, busy for 8 cycles, done 9 cycles after start.
REQ-035 Preload RAM[20..24]=1..5; start src=20, dst=22, count=5 -> RAM[22..26]=1..5, with addresses descending 24,26,23,25,...
REQ-036 Start src=268, dst=0, count=4 -> done plus error=1 after 1 cycle, ramWriteEnable never high, RAM unchanged.
REQ-037 Start with count=0 -> done after 1 cycle, error=0, no RAM access; a start pulsed during a 3-word copy -> ignored, exactly 3 writes.
REQ-038 Assert reset during the third WRITE of a 6-word copy -> next cycle all outputs at reset values, only 2 or 3 destination words written, FSM in IDLE.
